// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder: FSM state encoding, the default
// operand width and the majority function used by the full-adder cell.
// No ports.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int SA_WIDTH_DEFAULT = 8;

    // 2'd3 is unused; the FSM recovers from it by returning to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } sa_state_e;

    // Carry-out of a 1-bit full adder: true when at least two inputs are set.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// Combinational 1-bit full adder; the single arithmetic element that the
// serial adder steps its operands through.
// Ports:
//   x_i, y_i  operand bits
//   ci_i      carry in
//   s_o       sum bit     = x ^ y ^ ci
//   co_o      carry out   = majority(x, y, ci)
// -----------------------------------------------------------------------------
module full_adder_cell
    import serial_adder_pkg::*;
(
    input  logic x_i,
    input  logic y_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = x_i ^ y_i ^ ci_i;
    assign co_o = maj3(x_i, y_i, ci_i);

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder. Operands are captured on start (IDLE only) and
// fed LSB-first through one full_adder_cell, one bit per clock, with the carry
// held in a flip-flop between bit-steps. The result is presented with a
// one-cycle done pulse and held until the next accepted start.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf_o output
// (two's-complement overflow, registered with the final bit-step).
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   start_i  request, sampled only in IDLE
//   a_i      operand x, captured with start
//   b_i      operand y, captured with start
//   cin_i    carry-in, captured with start
//   busy_o   high in SHIFT and DONE
//   done_o   one-cycle pulse, sum_o/cout_o valid
//   sum_o    result, held until next accepted start
//   cout_o   final carry, held with sum_o
//   ovf_o    (SERIAL_ADDER_OVF_EN only) signed overflow, held with sum_o
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    sa_state_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             cell_sum_d;
    logic             cell_co_d;
    logic             last_step_d;

    full_adder_cell u_cell (
        .x_i  (ra_q[0]),
        .y_i  (rb_q[0]),
        .ci_i (carry_q),
        .s_o  (cell_sum_d),
        .co_o (cell_co_d)
    );

    assign last_step_d = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);

    // FSM, bit counter, operand/result shift registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            ra_q    <= {WIDTH{1'b0}};
            rb_q    <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        ra_q    <= a_i;
                        rb_q    <= b_i;
                        carry_q <= cin_i;
                        cnt_q   <= {CW{1'b0}};
                        sum_q   <= {WIDTH{1'b0}};
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    // Result enters at the MSB so after WIDTH steps bit 0 is the LSB sum.
                    ra_q    <= {1'b0, ra_q[WIDTH-1:1]};
                    rb_q    <= {1'b0, rb_q[WIDTH-1:1]};
                    sum_q   <= {cell_sum_d, sum_q[WIDTH-1:1]};
                    carry_q <= cell_co_d;
                    if (last_step_d) begin
                        cnt_q   <= {CW{1'b0}};
                        cout_q  <= cell_co_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1'b1);
                        state_q <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Overflow: carry into the MSB (carry FF on the last step) XOR carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start_i) begin
            ovf_q <= 1'b0;
        end else if (last_step_d) begin
            ovf_q <= carry_q ^ cell_co_d;
        end else begin
            ovf_q <= ovf_q;
        end
    end

    assign ovf_o = ovf_q;
`else
    // Overflow reporting not built in this configuration.
`endif

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8). A table of operand records
// with hand-derived results is applied in a loop; expected results are queued
// when start is driven and compared when done is seen. Hand-written sequences
// cover start while busy, reset mid-operation and start held high.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .cout_o  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_o   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t        e;
        logic [W:0]  t;
        t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic pop_and_check(input string tag);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected_done actual=1 expected=0", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_sum"}, 32'(sum), 32'(e.sum));
            chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input exp_t e, input string tag);
        int lat;
        bit seen;
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        sb_q.push_back(e);
        step();
        start = 1'b0;
        a     = ~x;
        b     = ~y;
        cin   = ~c;
        chk({tag, "_busy_cap"}, 32'(busy), 32'd1);
        chk({tag, "_sum_clr"}, 32'(sum), 32'd0);
        chk({tag, "_cout_clr"}, 32'(cout), 32'd0);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step();
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, 32'(lat), 32'(W));
            pop_and_check(tag);
            step();
            chk({tag, "_done_pulse"}, 32'(done), 32'd0);
            chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        end else begin
            sb_q.delete();
        end
    endtask

    initial begin
        int   dn;
        int   bl;
        exp_t e;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        step();

        // Table-driven operations.
        for (int i = 0; i < 8; i++) begin
            e.sum  = vecs[i].sum;
            e.cout = vecs[i].cout;
            e.ovf  = vecs[i].ovf;
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, e, $sformatf("vec%0d", i));
        end

        // Random operations against the arithmetic model.
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic         c;
            x = W'($urandom_range(0, 255));
            y = W'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            run_op(x, y, c, model(x, y, c), $sformatf("rnd%0d", i));
        end

        // Start pulsed again mid-operation with a different operand: ignored.
        a     = 8'h0F;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        sb_q.push_back('{8'h10, 1'b0, 1'b0});
        step();
        start = 1'b0;
        step();
        step();
        step();
        a     = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        dn    = 0;
        for (int k = 0; k < 15; k++) begin
            if (done) begin
                dn++;
                pop_and_check("restart_ign");
            end
            step();
        end
        chk("restart_done_count", 32'(dn), 32'd1);
        chk("restart_sb_empty", 32'(sb_q.size()), 32'd0);
        sb_q.delete();

        // Reset asserted mid-operation (partial result nonzero before reset).
        a     = 8'h0F;
        b     = 8'h00;
        cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("pre_rst_sum", 32'(sum), 32'hF0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        step();
        rst = 1'b0;
        dn  = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (done) dn++;
        end
        chk("arst_no_done", 32'(dn), 32'd0);
        chk("arst_idle", 32'(busy), 32'd0);
        run_op(8'h22, 8'h11, 1'b0, '{8'h33, 1'b0, 1'b0}, "post_rst");

        // Start held high: back-to-back operations every W+2 cycles.
        a     = 8'h0F;
        b     = 8'h01;
        cin   = 1'b0;
        for (int i = 0; i < 3; i++) sb_q.push_back('{8'h10, 1'b0, 1'b0});
        start = 1'b1;
        dn    = 0;
        bl    = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (done) begin
                dn++;
                chk("held_done_pos", 32'(k), 32'(W + (W + 2) * (dn - 1)));
                pop_and_check("held");
            end
            if (!busy) begin
                bl++;
                chk("held_busy_low_pos", 32'(k), 32'(W + 1 + (W + 2) * (bl - 1)));
            end
        end
        start = 1'b0;
        chk("held_done_count", 32'(dn), 32'd3);
        chk("held_busy_low_count", 32'(bl), 32'd3);
        chk("held_sb_empty", 32'(sb_q.size()), 32'd0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder
